// File: rtl/avr_arb_pkg.sv
// Shared types and width helpers for the AVR data-memory arbiter.
package avr_arb_pkg;

    typedef enum logic {
        ARB   = 1'b0,
        XLOCK = 1'b1
    } arb_state_t;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_EXT  = 1'b1
    } owner_t;

    // Bits needed to hold a starvation count of 0..max_wait.
    function automatic int unsigned wait_w(input int unsigned max_wait);
        return $clog2(max_wait + 1);
    endfunction

endpackage

// File: rtl/avr_arb_wait_cnt.sv
// Saturating starvation counter for the external port.
module avr_arb_wait_cnt
    import avr_arb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 8,
    parameter int unsigned WAIT_W   = wait_w(MAX_WAIT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    input  logic              clr,
    output logic [WAIT_W-1:0] cnt,
    output logic              sat
);

    localparam logic [WAIT_W-1:0] CNT_MAX = WAIT_W'(MAX_WAIT);

    // Clear wins over increment; hold once the limit is reached.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !sat) begin
            cnt <= cnt + WAIT_W'(1);
        end
    end

    assign sat = (cnt == CNT_MAX);

endmodule

// File: rtl/avr_dmem_arbiter.sv
// Arbiter/sequencer sharing the single-port data SRAM between core and external port.
module avr_dmem_arbiter
    import avr_arb_pkg::*;
#(
    parameter int unsigned AW       = 16,
    parameter int unsigned DW       = 8,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cfg_core_prio,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_gnt,
    output logic          core_rvalid,
    output logic [DW-1:0] core_rdata,
    input  logic          ext_req,
    input  logic          ext_we,
    input  logic          ext_lock,
    input  logic [AW-1:0] ext_addr,
    input  logic [DW-1:0] ext_wdata,
    output logic          ext_gnt,
    output logic          ext_rvalid,
    output logic [DW-1:0] ext_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int unsigned WAIT_W = wait_w(MAX_WAIT);

    arb_state_t        state_q;
    arb_state_t        state_d;
    owner_t            last_q;
    owner_t            last_d;
    owner_t            rd_owner_q;
    logic              rvalid_q;
    logic              wait_sat;
    logic [WAIT_W-1:0] unused_wait_q;

    // Ext starvation tracking: counts refused cycles, clears on grant or idle.
    avr_arb_wait_cnt #(
        .MAX_WAIT (MAX_WAIT),
        .WAIT_W   (WAIT_W)
    ) u_wait_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (ext_req && !ext_gnt),
        .clr   (!ext_req || ext_gnt),
        .cnt   (unused_wait_q),
        .sat   (wait_sat)
    );

    // FSM state and last-granted port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ARB;
            last_q  <= OWN_EXT;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Grant decision, lock entry/exit and round-robin history.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        core_gnt = 1'b0;
        ext_gnt  = 1'b0;
        if (reset) begin
            case (state_q)
                ARB: begin
                    if (core_req && ext_req) begin
                        ext_gnt  = cfg_core_prio ? wait_sat : (last_q == OWN_CORE);
                        core_gnt = !ext_gnt;
                    end else begin
                        core_gnt = core_req;
                        ext_gnt  = ext_req;
                    end
                    if (ext_gnt && ext_lock) begin
                        state_d = XLOCK;
                    end
                end
                XLOCK: begin
                    ext_gnt = ext_req;
                    if (!ext_req || !ext_lock) begin
                        state_d = ARB;
                    end
                end
                default: state_d = ARB;
            endcase
            if (core_gnt) begin
                last_d = OWN_CORE;
            end else if (ext_gnt) begin
                last_d = OWN_EXT;
            end
        end
    end

    // SRAM port mux; idle bus drives zeros.
    always_comb begin
        mem_en    = core_gnt || ext_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (ext_gnt) begin
            mem_we    = ext_we;
            mem_addr  = ext_addr;
            mem_wdata = ext_wdata;
        end else if (core_gnt) begin
            mem_we    = core_we;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
        end
    end

    // Remember who issued the read so next cycle's SRAM data is routed back.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rvalid_q   <= 1'b0;
            rd_owner_q <= OWN_CORE;
        end else begin
            rvalid_q <= mem_en && !mem_we;
            if (mem_en) begin
                rd_owner_q <= ext_gnt ? OWN_EXT : OWN_CORE;
            end
        end
    end

    // Read return steering; the non-owner sees zero data.
    always_comb begin
        core_rvalid = rvalid_q && (rd_owner_q == OWN_CORE);
        ext_rvalid  = rvalid_q && (rd_owner_q == OWN_EXT);
        core_rdata  = core_rvalid ? mem_rdata : '0;
        ext_rdata   = ext_rvalid ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_avr_dmem_arbiter.sv
// Directed self-checking bench for avr_dmem_arbiter with a behavioural SRAM.
module tb_avr_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        cfg_core_prio;
    logic        core_req;
    logic        core_we;
    logic [15:0] core_addr;
    logic [7:0]  core_wdata;
    logic        core_gnt;
    logic        core_rvalid;
    logic [7:0]  core_rdata;
    logic        ext_req;
    logic        ext_we;
    logic        ext_lock;
    logic [15:0] ext_addr;
    logic [7:0]  ext_wdata;
    logic        ext_gnt;
    logic        ext_rvalid;
    logic [7:0]  ext_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    int n_vec = 0;
    int n_err = 0;

    avr_dmem_arbiter #(
        .AW       (16),
        .DW       (8),
        .MAX_WAIT (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cfg_core_prio (cfg_core_prio),
        .core_req      (core_req),
        .core_we       (core_we),
        .core_addr     (core_addr),
        .core_wdata    (core_wdata),
        .core_gnt      (core_gnt),
        .core_rvalid   (core_rvalid),
        .core_rdata    (core_rdata),
        .ext_req       (ext_req),
        .ext_we        (ext_we),
        .ext_lock      (ext_lock),
        .ext_addr      (ext_addr),
        .ext_wdata     (ext_wdata),
        .ext_gnt       (ext_gnt),
        .ext_rvalid    (ext_rvalid),
        .ext_rdata     (ext_rdata),
        .mem_en        (mem_en),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Untouched SRAM locations read back a fixed address-derived pattern.
    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    logic [7:0] sram [int unsigned];

    // Synchronous single-port SRAM: read data valid the cycle after the read.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                sram[32'(mem_addr)] = mem_wdata;
            end else begin
                mem_rdata <= sram.exists(32'(mem_addr)) ? sram[32'(mem_addr)] : pat(mem_addr);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] ca;
        logic [15:0] ea;
        logic [15:0] prev_addr;
        logic        prev_core;
        logic        exp_core;
        logic        exp_ext;

        reset         = 1'b0;
        cfg_core_prio = 1'b0;
        core_req      = 1'b1;
        core_we       = 1'b0;
        core_addr     = 16'h0010;
        core_wdata    = 8'h00;
        ext_req       = 1'b1;
        ext_we        = 1'b0;
        ext_lock      = 1'b0;
        ext_addr      = 16'h0020;
        ext_wdata     = 8'h00;

        // Reset held with both ports requesting
        #2;
        check("rst_core_gnt", core_gnt, 0);
        check("rst_ext_gnt", ext_gnt, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_core_rvalid", core_rvalid, 0);
        check("rst_ext_rvalid", ext_rvalid, 0);
        check("rst_core_rdata", core_rdata, 0);
        tick();
        tick();
        check("rst_hold_core_gnt", core_gnt, 0);
        reset = 1'b1;

        // Round-robin: both read continuously, grants alternate starting with core
        ca        = 16'h0010;
        ea        = 16'h0020;
        prev_core = 1'b0;
        prev_addr = 16'h0000;
        for (int i = 0; i < 6; i++) begin
            #1;
            exp_core = (i % 2 == 0);
            check("rr_core_gnt", core_gnt, exp_core);
            check("rr_ext_gnt", ext_gnt, !exp_core);
            check("rr_mem_addr", mem_addr, exp_core ? ca : ea);
            if (i > 0) begin
                check("rr_core_rvalid", core_rvalid, prev_core);
                check("rr_ext_rvalid", ext_rvalid, !prev_core);
                check("rr_core_rdata", core_rdata, prev_core ? pat(prev_addr) : 8'h00);
                check("rr_ext_rdata", ext_rdata, prev_core ? 8'h00 : pat(prev_addr));
            end
            prev_core = exp_core;
            prev_addr = exp_core ? ca : ea;
            tick();
            if (exp_core) begin
                ca        = ca + 16'd1;
                core_addr = ca;
            end else begin
                ea       = ea + 16'd1;
                ext_addr = ea;
            end
        end
        core_req = 1'b0;
        ext_req  = 1'b0;
        #1;
        check("rr_last_ext_rvalid", ext_rvalid, 1);
        check("rr_last_ext_rdata", ext_rdata, pat(16'h0022));
        check("idle_mem_en", mem_en, 0);
        check("idle_mem_addr", mem_addr, 0);
        tick();

        // Core priority: ext starves 8 cycles then wins once, streak repeats
        cfg_core_prio = 1'b1;
        core_req      = 1'b1;
        ext_req       = 1'b1;
        for (int i = 0; i < 18; i++) begin
            #1;
            exp_ext = (i == 8) || (i == 17);
            check("prio_core_gnt", core_gnt, !exp_ext);
            check("prio_ext_gnt", ext_gnt, exp_ext);
            tick();
        end
        core_req      = 1'b0;
        ext_req       = 1'b0;
        cfg_core_prio = 1'b0;
        tick();

        // Lone core read so the round-robin tie next goes to ext
        core_req  = 1'b1;
        core_we   = 1'b0;
        core_addr = 16'h0030;
        #1;
        check("pre_lock_core_gnt", core_gnt, 1);
        tick();

        // Locked 4-beat ext write burst while core keeps requesting
        core_we    = 1'b1;
        core_addr  = 16'h0200;
        core_wdata = 8'h77;
        ext_req    = 1'b1;
        ext_we     = 1'b1;
        for (int b = 0; b < 4; b++) begin
            ext_addr  = 16'(16'h0100 + b);
            ext_wdata = 8'(8'hC0 + b);
            ext_lock  = (b < 3);
            #1;
            check("lock_ext_gnt", ext_gnt, 1);
            check("lock_core_gnt", core_gnt, 0);
            check("lock_mem_we", mem_we, 1);
            check("lock_mem_addr", mem_addr, 16'(16'h0100 + b));
            check("lock_mem_wdata", mem_wdata, 8'(8'hC0 + b));
            if (b == 0) begin
                check("lock_core_rvalid0", core_rvalid, 1);
                check("lock_core_rdata0", core_rdata, pat(16'h0030));
            end else begin
                check("lock_core_rvalid", core_rvalid, 0);
                check("lock_ext_rvalid", ext_rvalid, 0);
            end
            tick();
        end
        ext_req  = 1'b0;
        ext_lock = 1'b0;
        ext_we   = 1'b0;
        #1;
        check("post_lock_core_gnt", core_gnt, 1);
        check("post_lock_mem_addr", mem_addr, 16'h0200);
        check("post_lock_mem_we", mem_we, 1);
        tick();
        core_req = 1'b0;

        // Read back the burst through the ext port
        for (int b = 0; b < 4; b++) begin
            ext_req  = 1'b1;
            ext_addr = 16'(16'h0100 + b);
            #1;
            check("rb_ext_gnt", ext_gnt, 1);
            if (b > 0) begin
                check("rb_ext_rvalid", ext_rvalid, 1);
                check("rb_ext_rdata", ext_rdata, 8'(8'hC0 + b - 1));
            end
            tick();
        end
        ext_req   = 1'b0;
        core_req  = 1'b1;
        core_we   = 1'b0;
        core_addr = 16'h0200;
        #1;
        check("rb_ext_rvalid3", ext_rvalid, 1);
        check("rb_ext_rdata3", ext_rdata, 8'hC3);
        check("rb_core_gnt", core_gnt, 1);
        tick();
        core_req = 1'b0;
        #1;
        check("rb_core_rvalid", core_rvalid, 1);
        check("rb_core_rdata", core_rdata, 8'h77);
        check("rb_ext_rdata_zero", ext_rdata, 0);
        tick();

        // Lock abort: ext drops req mid-lock, core granted the cycle after
        ext_req   = 1'b1;
        ext_we    = 1'b1;
        ext_lock  = 1'b1;
        ext_addr  = 16'h0300;
        ext_wdata = 8'h11;
        #1;
        check("abort_ext_gnt0", ext_gnt, 1);
        tick();
        core_req  = 1'b1;
        core_we   = 1'b0;
        core_addr = 16'h0040;
        ext_addr  = 16'h0301;
        #1;
        check("abort_ext_gnt1", ext_gnt, 1);
        check("abort_core_blocked", core_gnt, 0);
        tick();
        ext_req = 1'b0;
        #1;
        check("abort_drop_core_gnt", core_gnt, 0);
        check("abort_drop_mem_en", mem_en, 0);
        tick();
        #1;
        check("abort_core_gnt", core_gnt, 1);
        tick();

        // Reset asserted while that core read is returning: return is dropped
        core_req = 1'b0;
        reset    = 1'b0;
        #1;
        check("rstrd_core_rvalid_a", core_rvalid, 0);
        check("rstrd_core_rdata_a", core_rdata, 0);
        tick();
        reset = 1'b1;
        #1;
        check("rstrd_core_rvalid_b", core_rvalid, 0);
        tick();
        check("rstrd_core_rvalid_c", core_rvalid, 0);

        // After reset, first round-robin tie goes to core
        core_req = 1'b1;
        ext_req  = 1'b1;
        ext_we   = 1'b0;
        ext_lock = 1'b0;
        #1;
        check("rst_tie_core_gnt", core_gnt, 1);
        check("rst_tie_ext_gnt", ext_gnt, 0);
        tick();
        core_req = 1'b0;
        ext_req  = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
